// File: rtl/clique_collector.sv
// Clique stream collector: tracks the maximum clique size, counts cliques of that size
// and buffers their vertex lists for host readback. Optional macro: CLQ_ORDER_CHECK_EN.
module clique_collector #(
  parameter int VW    = 10,
  parameter int SW    = 5,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [SW-1:0] i_init_maxsize,
  input  logic [SW-1:0] i_clq_size,
  input  logic [VW-1:0] i_clq_v,
  input  logic          i_clq_valid,
  input  logic [AW-1:0] i_rd_addr,
  output logic [VW-1:0] o_rd_data,
  output logic [SW-1:0] o_maxsize,
  output logic [31:0]   o_n_cliques,
  output logic [AW:0]   o_n_entries,
  output logic          o_overflow,
  output logic          o_len_err,
  output logic          o_active
`ifdef CLQ_ORDER_CHECK_EN
  ,
  output logic          o_order_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state;
  logic [SW-1:0] bs;
  logic [SW:0]   bc;
  logic          keep;

  logic          wr_req;
  logic          restart;
  logic          wr_full;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  logic [VW-1:0] mem [DEPTH];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_req  = 1'b0;
    restart = 1'b0;
    if (!i_start && i_clq_valid) begin
      if (state == S_IDLE) begin
        if (i_clq_size > o_maxsize) begin
          wr_req  = 1'b1;
          restart = 1'b1;
        end else if (i_clq_size == o_maxsize) begin
          wr_req = 1'b1;
        end
      end else if (state == S_ACTIVE && keep) begin
        wr_req = 1'b1;
      end
    end
    wr_full = wr_req && !restart && (o_n_entries == FULL);
    wr_en   = wr_req && !wr_full;
    wr_addr = restart ? '0 : o_n_entries[AW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      bs          <= '0;
      bc          <= '0;
      keep        <= 1'b0;
      o_maxsize   <= '0;
      o_n_cliques <= '0;
      o_n_entries <= '0;
      o_overflow  <= 1'b0;
      o_len_err   <= 1'b0;
    end else if (i_start) begin
      // A start that lands on a valid beat must let the rest of that burst drain unseen.
      state       <= i_clq_valid ? S_DRAIN : S_IDLE;
      keep        <= 1'b0;
      o_maxsize   <= i_init_maxsize;
      o_n_cliques <= '0;
      o_n_entries <= '0;
      o_overflow  <= 1'b0;
      o_len_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_clq_valid) begin
            bs    <= i_clq_size;
            bc    <= (SW+1)'(1);
            state <= S_ACTIVE;
            if (i_clq_size > o_maxsize) begin
              o_maxsize   <= i_clq_size;
              o_n_cliques <= 32'd1;
              keep        <= 1'b1;
            end else if (i_clq_size == o_maxsize) begin
              if (o_n_cliques != '1) o_n_cliques <= o_n_cliques + 32'd1;
              keep <= 1'b1;
            end else begin
              keep <= 1'b0;
            end
          end
        end
        S_ACTIVE: begin
          if (i_clq_valid) begin
            if (bc != '1) bc <= bc + (SW+1)'(1);
          end else begin
            state <= S_IDLE;
            if (bc != {1'b0, bs}) o_len_err <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!i_clq_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (restart) begin
        o_n_entries <= (AW+1)'(1);
        o_overflow  <= 1'b0;
      end else if (wr_en) begin
        o_n_entries <= o_n_entries + (AW+1)'(1);
      end else if (wr_full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  assign o_active = (state == S_ACTIVE);

  // NOTE: the vertex store is deliberately not reset; it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= i_clq_v;
  end

  // Registered read returns the pre-write contents on a same-address collision.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_rd_data <= '0;
    else         o_rd_data <= mem[i_rd_addr];
  end

`ifdef CLQ_ORDER_CHECK_EN
  logic [VW-1:0] prev_v;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_v      <= '0;
      o_order_err <= 1'b0;
    end else if (i_start) begin
      o_order_err <= 1'b0;
    end else if (i_clq_valid && state != S_DRAIN) begin
      prev_v <= i_clq_v;
      if (state == S_ACTIVE && i_clq_v <= prev_v) o_order_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clique_collector.sv
// Self-checking bench for clique_collector: vector table, hand-written corner sequences
// and randomized bursts checked against a burst-level reference model.
module tb_clique_collector;

  localparam int VW    = 10;
  localparam int SW    = 5;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [SW-1:0] i_init_maxsize;
  logic [SW-1:0] i_clq_size;
  logic [VW-1:0] i_clq_v;
  logic          i_clq_valid;
  logic [AW-1:0] i_rd_addr;
  logic [VW-1:0] o_rd_data;
  logic [SW-1:0] o_maxsize;
  logic [31:0]   o_n_cliques;
  logic [AW:0]   o_n_entries;
  logic          o_overflow;
  logic          o_len_err;
  logic          o_active;
`ifdef CLQ_ORDER_CHECK_EN
  logic          o_order_err;
`endif

  clique_collector #(.VW(VW), .SW(SW), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_init_maxsize (i_init_maxsize),
    .i_clq_size     (i_clq_size),
    .i_clq_v        (i_clq_v),
    .i_clq_valid    (i_clq_valid),
    .i_rd_addr      (i_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_maxsize      (o_maxsize),
    .o_n_cliques    (o_n_cliques),
    .o_n_entries    (o_n_entries),
    .o_overflow     (o_overflow),
    .o_len_err      (o_len_err),
    .o_active       (o_active)
`ifdef CLQ_ORDER_CHECK_EN
    ,
    .o_order_err    (o_order_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, updated once per whole burst.
  int unsigned m_max;
  int unsigned m_ncl;
  int unsigned m_store[$];
  bit          m_ovf;
  bit          m_len;
  bit          m_ord;
  int unsigned bq[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear(input int unsigned init);
    m_max = init;
    m_ncl = 0;
    m_store.delete();
    m_ovf = 0;
    m_len = 0;
    m_ord = 0;
  endtask

  task automatic model_burst(input int unsigned sz);
    bit keep;
    keep = 0;
    if (sz > m_max) begin
      m_max = sz;
      m_ncl = 1;
      m_store.delete();
      m_ovf = 0;
      keep  = 1;
    end else if (sz == m_max) begin
      m_ncl++;
      keep = 1;
    end
    if (keep) begin
      foreach (bq[k]) begin
        if (m_store.size() < DEPTH) m_store.push_back(bq[k]);
        else m_ovf = 1;
      end
    end
    if (bq.size() != sz) m_len = 1;
    for (int k = 1; k < bq.size(); k++)
      if (bq[k] <= bq[k-1]) m_ord = 1;
  endtask

  task automatic do_start(input int unsigned init);
    @(negedge i_clk);
    i_start        = 1'b1;
    i_init_maxsize = SW'(init);
    @(negedge i_clk);
    i_start = 1'b0;
    model_clear(init);
  endtask

  // Drives the beats in bq, then one idle cycle; the model follows the burst.
  task automatic send(input int unsigned sz);
    for (int k = 0; k < bq.size(); k++) begin
      @(negedge i_clk);
      i_clq_valid = 1'b1;
      i_clq_size  = SW'(sz);
      i_clq_v     = VW'(bq[k]);
    end
    @(negedge i_clk);
    i_clq_valid = 1'b0;
    check("active_in_burst", o_active, 1);
    @(negedge i_clk);
    model_burst(sz);
  endtask

  task automatic check_model(input string name);
    check({name, ".maxsize"},   o_maxsize,   m_max);
    check({name, ".n_cliques"}, o_n_cliques, m_ncl);
    check({name, ".n_entries"}, o_n_entries, m_store.size());
    check({name, ".overflow"},  o_overflow,  m_ovf);
    check({name, ".len_err"},   o_len_err,   m_len);
    check({name, ".active"},    o_active,    0);
`ifdef CLQ_ORDER_CHECK_EN
    check({name, ".order_err"}, o_order_err, m_ord);
`endif
  endtask

  task automatic check_store(input string name);
    for (int i = 0; i < m_store.size(); i++) begin
      @(negedge i_clk);
      i_rd_addr = AW'(i);
      @(negedge i_clk);
      check($sformatf("%s[%0d]", name, i), o_rd_data, m_store[i]);
    end
  endtask

  typedef struct {
    int unsigned sz;
    int unsigned nb;
    int unsigned v[4];
    int unsigned exp_max;
    int unsigned exp_ncl;
    int unsigned exp_nent;
    int unsigned exp_len;
  } vec_t;

  vec_t tbl[5];
  int unsigned exp_rd[6];

  initial begin
    tbl[0] = '{3, 3, '{1, 4, 7, 0},   3, 1, 3, 0};
    tbl[1] = '{3, 3, '{2, 5, 9, 0},   3, 2, 6, 0};
    tbl[2] = '{4, 4, '{0, 3, 6, 8},   4, 1, 4, 0};
    tbl[3] = '{2, 2, '{1, 2, 0, 0},   4, 1, 4, 0};
    tbl[4] = '{4, 3, '{10, 11, 12, 0}, 4, 2, 7, 1};
    exp_rd = '{1, 4, 7, 2, 5, 9};

    i_reset        = 1'b1;
    i_start        = 1'b0;
    i_init_maxsize = '0;
    i_clq_size     = '0;
    i_clq_v        = '0;
    i_clq_valid    = 1'b0;
    i_rd_addr      = '0;
    model_clear(0);

    #1;
    check("reset.maxsize",   o_maxsize,   0);
    check("reset.n_cliques", o_n_cliques, 0);
    check("reset.n_entries", o_n_entries, 0);
    check("reset.flags",     {o_overflow, o_len_err, o_active}, 0);
    check("reset.rd_data",   o_rd_data,   0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;

    // Vector table: the directed scenario, burst by burst.
    do_start(2);
    for (int t = 0; t < 5; t++) begin
      bq.delete();
      for (int k = 0; k < tbl[t].nb; k++) bq.push_back(tbl[t].v[k]);
      send(tbl[t].sz);
      check($sformatf("vec%0d.maxsize", t),   o_maxsize,   tbl[t].exp_max);
      check($sformatf("vec%0d.n_cliques", t), o_n_cliques, tbl[t].exp_ncl);
      check($sformatf("vec%0d.n_entries", t), o_n_entries, tbl[t].exp_nent);
      check($sformatf("vec%0d.len_err", t),   o_len_err,   tbl[t].exp_len);
      if (t == 1) begin
        for (int i = 0; i < 6; i++) begin
          @(negedge i_clk);
          i_rd_addr = AW'(i);
          @(negedge i_clk);
          check($sformatf("vec1.rd[%0d]", i), o_rd_data, exp_rd[i]);
        end
      end
      if (t == 2) begin
        @(negedge i_clk);
        i_rd_addr = '0;
        @(negedge i_clk);
        check("vec2.rd[0]", o_rd_data, 0);
      end
    end
    check_store("vec_store");

    // Store fill: 33 size-4 bursts overflow a 128-entry store.
    do_start(0);
    for (int b = 0; b < 33; b++) begin
      bq.delete();
      for (int k = 0; k < 4; k++) bq.push_back(b * 4 + k);
      send(4);
    end
    check("full.n_entries", o_n_entries, 128);
    check("full.overflow",  o_overflow,  1);
    check("full.n_cliques", o_n_cliques, 33);
    check_model("full");
    check_store("full_store");
    bq = '{20, 21, 22, 23, 24};
    send(5);
    check("restart.overflow",  o_overflow,  0);
    check("restart.n_entries", o_n_entries, 5);
    check_model("restart");
    check_store("restart_store");

    // Start on the second beat of a burst: rest of the burst is ignored.
    @(negedge i_clk);
    i_clq_valid = 1'b1; i_clq_size = SW'(3); i_clq_v = VW'(1);
    @(negedge i_clk);
    i_clq_v = VW'(4); i_start = 1'b1; i_init_maxsize = SW'(1);
    @(negedge i_clk);
    i_start = 1'b0; i_clq_v = VW'(7);
    @(negedge i_clk);
    i_clq_valid = 1'b0;
    model_clear(1);
    check_model("start_mid");
    @(negedge i_clk);
    check_model("start_gap");
    bq = '{3, 6};
    send(2);
    check_model("after_start");
    check_store("after_start_store");

    // Asynchronous reset in the middle of a burst.
    @(negedge i_clk);
    i_clq_valid = 1'b1; i_clq_size = SW'(2); i_clq_v = VW'(8);
    @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    check("areset.maxsize",   o_maxsize,   0);
    check("areset.n_cliques", o_n_cliques, 0);
    check("areset.n_entries", o_n_entries, 0);
    check("areset.active",    o_active,    0);
    check("areset.rd_data",   o_rd_data,   0);
    @(negedge i_clk);
    i_clq_valid = 1'b0;
    i_reset     = 1'b0;
    model_clear(0);

`ifdef CLQ_ORDER_CHECK_EN
    do_start(0);
    bq = '{5, 3, 9};
    send(3);
    check("order.bad", o_order_err, 1);
    do_start(0);
    bq = '{1, 2, 3};
    send(3);
    check("order.good", o_order_err, 0);
`endif

    // Randomized bursts against the reference model.
    do_start($urandom_range(0, 3));
    for (int b = 0; b < 160; b++) begin
      int unsigned sz, nb, v;
      if (b == 80) do_start($urandom_range(0, 4));
      sz = $urandom_range(1, 6);
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : sz;
      v  = $urandom_range(0, 100);
      bq.delete();
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 1023);
        else v = (v + $urandom_range(1, 20)) % 1024;
        bq.push_back(v);
      end
      send(sz);
      check_model($sformatf("rnd%0d", b));
      if (b % 40 == 39) check_store($sformatf("rnd%0d_store", b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clique_collector.md
Name: clique_collector

Overview:
- Sits directly downstream of justwu_top and consumes its clique stream (o_clq_size / o_clq_v / o_clq_valid).
- Each clique arrives as a burst of consecutive valid cycles, one vertex index per cycle.
- Tracks the running maximum clique size and counts the cliques of that size.
- Buffers their vertex lists in an on-chip store for host readback, so maxsize, clique-count and vertex-list checking moves into hardware.

Parameters:
VW, 10, vertex index width (matches MATRIX_WIDTHV)
SW, 5, clique size width (matches MAX_CLIQUESIZEBITS)
DEPTH, 128, vertex store entries (power of two)
AW, 7, log2(DEPTH)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_start  in  1  one-cycle pulse: clear store and counters, load i_init_maxsize
i_init_maxsize  in  SW  starting maxsize, sampled on i_start
i_clq_size  in  SW  size of current clique; valid on the first cycle of a burst
i_clq_v  in  VW  vertex index, one per valid cycle
i_clq_valid  in  1  burst valid
i_rd_addr  in  AW  store read address
o_rd_data  out  VW  store read data, 1-cycle latency
o_maxsize  out  SW  current maximum clique size
o_n_cliques  out  32  number of cliques of size o_maxsize, saturating
o_n_entries  out  AW+1  vertices held in store (0..DEPTH)
o_overflow  out  1  sticky: store write dropped since last clear
o_len_err  out  1  sticky: burst length differed from its i_clq_size
o_active  out  1  high while inside a burst

Behaviour:
- Reset (asynchronous) values:
  - all counters 0; o_maxsize 0; flags 0; o_active 0; state S_IDLE; o_rd_data 0.
  - Store contents are not reset.
- State S_IDLE, on i_clq_valid=1 (first beat):
  - Latch i_clq_size as burst size bs; beat count bc=1; go to S_ACTIVE.
  - bs > o_maxsize:
    - o_maxsize<=bs; o_n_cliques<=1.
    - Write i_clq_v at address 0; o_n_entries<=1.
    - Clear o_overflow; mode KEEP.
  - bs == o_maxsize:
    - o_n_cliques+=1 (saturates at 2^32-1).
    - Write at o_n_entries; o_n_entries+=1; mode KEEP.
  - bs < o_maxsize: mode DROP; no write; no count change.
- State S_ACTIVE:
  - On valid, in mode KEEP: write i_clq_v at o_n_entries, increment o_n_entries; bc+=1.
  - On valid, in mode DROP: bc+=1 only.
  - On valid=0: go to S_IDLE. If bc != bs, set o_len_err (KEEP and DROP alike).
- Gaps between bursts:
  - Bursts are separated by at least one invalid cycle.
  - There is no back-to-back burst detection; a continuous valid run is one burst.
- Store full:
  - A KEEP write with o_n_entries==DEPTH is discarded and sets o_overflow.
  - o_n_entries holds at DEPTH; counting continues.
- A new larger clique restarts the store at address 0 even when the store is full.
- i_start:
  - o_maxsize<=i_init_maxsize; o_n_cliques, o_n_entries, o_overflow, o_len_err <=0; state S_IDLE.
  - Wins over a simultaneous valid beat; that beat is ignored.
  - If i_start lands mid-burst, the remainder of that burst is ignored: the collector waits for valid=0 before accepting a new first beat.
- o_active = (state==S_ACTIVE).
- Read port:
  - o_rd_data is the registered store[i_rd_addr], 1-cycle latency.
  - Read-during-write to the same address returns the old data.
- Mid-operation reset: asynchronous reset clears everything immediately, including a burst in progress.

Optional Feature:
CLQ_ORDER_CHECK_EN
- Defined:
  - Adds output o_order_err (1, sticky, cleared by reset/i_start).
  - Set when, within any burst, a vertex is not strictly greater than the previous vertex of that burst. Checked in KEEP and DROP modes.
- Undefined: port and logic are absent; ordering is not checked.

Test Plan:
- Start with init_maxsize=2; burst size 3 vertices {1,4,7}; then burst size 3 {2,5,9} -> o_maxsize=3, o_n_cliques=2, o_n_entries=6, read addr 0..5 yields 1,4,7,2,5,9 one cycle after address.
- Continuing the scenario above, burst size 4 {0,3,6,8} -> o_maxsize=4, o_n_cliques=1, o_n_entries=4, addr0=0; then a size-2 burst -> no change.
- Init_maxsize=0; 33 size-4 bursts (132 beats) with DEPTH=128 -> o_n_entries=128, o_overflow=1, o_n_cliques=33; then a size-5 burst -> o_overflow=0, o_n_entries=5.
- Burst declaring size 3 but carrying 2 beats -> o_len_err=1 after valid falls; counts still updated as KEEP.
- i_start asserted on the 2nd beat of a burst -> counters cleared, remaining beats ignored, next burst after a gap accepted normally; async reset mid-burst -> all outputs 0 in the same cycle.
- With CLQ_ORDER_CHECK_EN defined: burst {5,3,9} -> o_order_err=1; burst {1,2,3} after i_start -> o_order_err stays 0.
